bpu_btb: RTL and testbench
==========================

// Module: bpu_btb
// PURPOSE
//  Parametrised branch target buffer with 2-bit saturating-counter direction predictor.
//  Fetch looks up the PC; prediction and target are returned one cycle later.
//  The branch resolution stage (ID) writes outcomes through a separate update port.
//  Successor to the fixed 256-entry BPU: tagged entries, valid bits, independent lookup/update ports, optional gshare.
// PARAMETERS
//  XLEN      32   PC/target width
//  IDX_W     8    index width; DEPTH = 2**IDX_W entries
//  TAG_W     22   tag width, PC[IDX_W+2+TAG_W-1 : IDX_W+2]; IDX_W+2+TAG_W <= XLEN
//  GHR_W     8    global history length, used only with BPU_GSHARE_EN; GHR_W <= IDX_W
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      asynchronous active-low reset
//  i_lookup_valid in   1      fetch lookup request
//  i_lookup_pc    in   XLEN   fetch PC
//  o_pred_valid   out  1      registered: lookup hit on a valid entry with matching tag
//  o_pred_taken   out  1      registered: counter MSB of hit entry (WT/ST)
//  o_pred_target  out  XLEN   registered: stored target on hit, else 0
//  i_upd_valid    in   1      resolved branch update strobe
//  i_upd_pc       in   XLEN   PC of resolved branch
//  i_upd_target   in   XLEN   resolved target address
//  i_upd_taken    in   1      actual direction
// BEHAVIOUR
//  - Clock is clk; reset is asynchronous, active-low on rst_n.
//  - Reset: all valid bits 0, all counters WNT (2'b01), GHR 0, o_pred_valid/o_pred_taken 0, o_pred_target 0.
//    Tags/targets need not be reset. Reset asserted mid-operation discards any in-flight lookup.
//  - Index = PC[IDX_W+1:2] (word-aligned); tag compare uses the TAG_W bits above the index.
//  - Lookup: latency 1. Outputs registered on the clk edge after i_lookup_valid=1.
//    i_lookup_valid=0 -> next cycle o_pred_valid=0, o_pred_taken=0, o_pred_target=0.
//    Miss (invalid or tag mismatch) -> o_pred_valid=0, o_pred_taken=0, o_pred_target=0.
//  - Update (one per cycle, applied at clk edge when i_upd_valid=1):
//    hit  -> counter saturating +1 if taken, -1 if not (ST holds at 11, SNT holds at 00);
//            target overwritten with i_upd_target only when taken.
//    miss -> allocate/replace: valid=1, tag, target=i_upd_target, counter = taken ? WT : WNT.
//  - Same-cycle lookup and update to the same entry: lookup returns pre-update contents
//    (read-before-write). The update is fully applied for the following lookup.
//  - Counters are stored in a separate array from tag/target/valid.
//    The counter index may differ from the BTB index (see CONFIGURATION).
//  - No stalls or backpressure; both ports are accepted every cycle.
// CONFIGURATION
//  BPU_GSHARE_EN defined:
//    counter index = PC[IDX_W+1:2] XOR {GHR zero-extended to IDX_W bits}.
//    GHR <= {GHR[GHR_W-2:0], i_upd_taken} on each i_upd_valid.
//    The lookup uses the GHR value before that cycle's shift.
//    BTB tag/target/valid indexing is unchanged.
//  BPU_GSHARE_EN undefined: counter index = BTB index; no GHR register is built.
// TESTING
//  1 Reset, then lookup 0x0000_1000 -> o_pred_valid=0, o_pred_taken=0, o_pred_target=0.
//  2 Update pc=0x1000, tgt=0x2000, taken=1; then lookup 0x1000
//      -> valid=1, taken=1 (WT), target=0x2000.
//  3 Three not-taken updates of 0x1000 after test 2 -> counter SNT, lookup taken=0;
//      a 4th not-taken update keeps SNT; two taken updates -> WT, taken=1.
//  4 Aliasing: update 0x1000, then pc=0x1000+(4<<IDX_W) -> lookup 0x1000 misses (valid=0);
//      the new PC hits.
//  5 Same-cycle lookup+update on 0x1000 (taken, tgt 0x3000) -> old data returned;
//      next lookup shows tgt 0x3000.
//  6 Assert rst_n low mid-stream between lookup and output edge -> outputs 0 immediately;
//      all prior entries miss. With BPU_GSHARE_EN, alternating taken/not-taken history
//      trains separate counters for the same PC.

Source files
------------

// File: rtl/bpu_btb.sv
// Tagged branch target buffer with 2-bit saturating direction counters, 1-cycle lookup.
// Optional gshare counter indexing is enabled by defining BPU_GSHARE_EN.
module bpu_btb #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 8,
  parameter int TAG_W = 22,
  parameter int GHR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_lookup_valid,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_pred_valid,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];
  logic [1:0]       ctr_q [DEPTH];

  logic [IDX_W-1:0] l_idx, u_idx, l_cidx, u_cidx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic [1:0]       u_ctr, ctr_nxt;

  assign l_idx = i_lookup_pc[IDX_W+1:2];
  assign u_idx = i_upd_pc[IDX_W+1:2];
  assign l_tag = i_lookup_pc[IDX_W+2 +: TAG_W];
  assign u_tag = i_upd_pc[IDX_W+2 +: TAG_W];

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_ext;

  assign ghr_ext = IDX_W'(ghr_q);
  assign l_cidx  = l_idx ^ ghr_ext;
  assign u_cidx  = u_idx ^ ghr_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (i_upd_valid) begin
      ghr_q <= GHR_W'({ghr_q, i_upd_taken});
    end
  end
`else
  assign l_cidx = l_idx;
  assign u_cidx = u_idx;
`endif

  logic unused_pc_lo;
  assign unused_pc_lo = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  if (XLEN > IDX_W + 2 + TAG_W) begin : g_hi_unused
    logic unused_pc_hi;
    assign unused_pc_hi = ^{i_lookup_pc[XLEN-1:IDX_W+2+TAG_W], i_upd_pc[XLEN-1:IDX_W+2+TAG_W]};
  end

  assign l_hit = i_lookup_valid && valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_ctr = ctr_q[u_cidx];

  always_comb begin
    ctr_nxt = i_upd_taken ? 2'b10 : 2'b01;
    if (u_hit) begin
      if (i_upd_taken) ctr_nxt = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
      else             ctr_nxt = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
    end
  end

  // Lookup samples array state before this edge's update: read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      o_pred_valid  <= 1'b0;
      o_pred_taken  <= 1'b0;
      o_pred_target <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
    end else begin
      o_pred_valid  <= l_hit;
      o_pred_taken  <= l_hit && ctr_q[l_cidx][1];
      o_pred_target <= l_hit ? tgt_q[l_idx] : '0;
      if (i_upd_valid) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_cidx]  <= ctr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_upd_valid) begin
      tag_q[u_idx] <= u_tag;
      if (!u_hit || i_upd_taken) tgt_q[u_idx] <= i_upd_target;
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Bench for bpu_btb: reference model of the BTB table plus directed literal checks.
// Define BPU_GSHARE_EN for both bench and RTL to cover the gshare build.
module tb_bpu_btb;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lv = 1'b0;
  logic [31:0] lpc = '0;
  logic        uv = 1'b0;
  logic [31:0] upc = '0;
  logic [31:0] utgt = '0;
  logic        ut = 1'b0;
  logic        pv, pt;
  logic [31:0] ptgt;

  int tests_run = 0;
  int tests_failed = 0;

  bpu_btb #(.XLEN(32), .IDX_W(8), .TAG_W(22), .GHR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_lookup_valid(lv), .i_lookup_pc(lpc),
    .o_pred_valid(pv), .o_pred_taken(pt), .o_pred_target(ptgt),
    .i_upd_valid(uv), .i_upd_pc(upc), .i_upd_target(utgt), .i_upd_taken(ut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table of entries keyed by PC word index.
  bit          m_valid [DEPTH];
  logic [21:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  int          m_ghr;
  logic        e_v, e_t;
  logic [31:0] e_tgt;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic int cidx_of(logic [31:0] pc);
`ifdef BPU_GSHARE_EN
    return idx_of(pc) ^ (m_ghr % 256);
`else
    return idx_of(pc);
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i] = 1;
      end
      m_ghr = 0;
      e_v = 1'b0; e_t = 1'b0; e_tgt = '0;
    end else begin
      int li, ui, uc;
      bit uhit;
      li = idx_of(lpc);
      e_v = lv && m_valid[li] && (m_tag[li] == lpc[31:10]);
      e_t = e_v && (m_ctr[cidx_of(lpc)] >= 2);
      e_tgt = e_v ? m_tgt[li] : 32'h0;
      if (uv) begin
        ui = idx_of(upc);
        uc = cidx_of(upc);
        uhit = m_valid[ui] && (m_tag[ui] == upc[31:10]);
        if (uhit) begin
          m_ctr[uc] = ut ? ((m_ctr[uc] + 1 > 3) ? 3 : m_ctr[uc] + 1)
                         : ((m_ctr[uc] - 1 < 0) ? 0 : m_ctr[uc] - 1);
          if (ut) m_tgt[ui] = utgt;
        end else begin
          m_valid[ui] = 1'b1;
          m_tag[ui] = upc[31:10];
          m_tgt[ui] = utgt;
          m_ctr[uc] = ut ? 2 : 1;
        end
        m_ghr = ((m_ghr << 1) | int'(ut)) & 255;
      end
    end
    #1;
    check("model_valid", {31'b0, pv}, {31'b0, e_v});
    check("model_taken", {31'b0, pt}, {31'b0, e_t});
    check("model_target", ptgt, e_tgt);
  end

  // Drives one cycle of stimulus; returns once that cycle's lookup result is visible.
  task automatic step(input logic l_v, input logic [31:0] l_pc, input logic u_v,
                      input logic [31:0] u_pc, input logic [31:0] u_tgt, input logic u_t);
    @(negedge clk);
    lv = l_v; lpc = l_pc; uv = u_v; upc = u_pc; utgt = u_tgt; ut = u_t;
    @(posedge clk);
    #2;
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic t);
    step(1'b0, '0, 1'b1, pc, tgt, t);
  endtask

  task automatic lit(input string name, input logic v, input logic t, input logic [31:0] tgt);
    check({name, "_valid"}, {31'b0, pv}, {31'b0, v});
    check({name, "_taken"}, {31'b0, pt}, {31'b0, t});
    check({name, "_target"}, ptgt, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    lookup(32'h1000);
    lit("cold_miss", 1'b0, 1'b0, 32'h0);

    update(32'h1000, 32'h2000, 1'b1);
    lookup(32'h1000);
    lit("alloc_wt", 1'b1, 1'b1, 32'h2000);

    repeat (3) update(32'h1000, 32'h9999, 1'b0);
    lookup(32'h1000);
    lit("snt", 1'b1, 1'b0, 32'h2000);
    update(32'h1000, 32'h9999, 1'b0);
    lookup(32'h1000);
    lit("snt_hold", 1'b1, 1'b0, 32'h2000);
    update(32'h1000, 32'h2004, 1'b1);
    update(32'h1000, 32'h2004, 1'b1);
    lookup(32'h1000);
`ifndef BPU_GSHARE_EN
    lit("back_to_wt", 1'b1, 1'b1, 32'h2004);
`endif

    step(1'b0, 32'h1000, 1'b0, '0, '0, 1'b0);
    lit("idle", 1'b0, 1'b0, 32'h0);

    update(32'h1400, 32'h5000, 1'b0);
    lookup(32'h1000);
    lit("alias_evicted", 1'b0, 1'b0, 32'h0);
    lookup(32'h1400);
    lit("alias_new", 1'b1, 1'b0, 32'h5000);

    update(32'h1000, 32'h2000, 1'b1);
    step(1'b1, 32'h1000, 1'b1, 32'h1000, 32'h3000, 1'b1);
    lit("rbw_old", 1'b1, 1'b1, 32'h2000);
    lookup(32'h1000);
`ifndef BPU_GSHARE_EN
    lit("rbw_new", 1'b1, 1'b1, 32'h3000);
`else
    check("rbw_new_target", ptgt, 32'h3000);
`endif

    for (int i = 0; i < 12; i++) update(32'h0000_8000 + 32'(i * 4), 32'h0000_A000 + 32'(i), i[0]);
    for (int i = 0; i < 12; i++) update(32'h0000_8000 + 32'(i * 4), 32'h0000_B000 + 32'(i), i[1]);
    for (int i = 0; i < 14; i++) lookup(32'h0000_8000 + 32'(i * 4));
    lookup(32'h0000_8004);
    check("table_target", ptgt, 32'h0000_A001);

    lookup(32'h1000);
    @(negedge clk);
    lv = 1'b1; lpc = 32'h1000;
    #2 rst_n = 1'b0;
    #1;
    lit("async_reset", 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    lookup(32'h1000);
    lit("post_reset_a", 1'b0, 1'b0, 32'h0);
    lookup(32'h1400);
    lit("post_reset_b", 1'b0, 1'b0, 32'h0);

`ifdef BPU_GSHARE_EN
    update(32'h1000, 32'h2000, 1'b1);
    update(32'h1000, 32'h2000, 1'b0);
    lookup(32'h1000);
    lit("gshare_fresh_ctr", 1'b1, 1'b0, 32'h2000);
    for (int i = 0; i < 16; i++) update(32'h1000, 32'h2000, i[0]);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1000, 1'b1, 32'h1000, 32'h2000, i[0]);
`endif

    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
